// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV32I
// load/store funct3 encodings and the default top of data memory.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [31:0] MEM_TOP_DEFAULT = 32'h0001FFFF;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Halfwords are split into two byte accesses.
    function automatic logic f3_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extension: builds the architectural load result
// from the captured low byte, high byte and full word.
module load_extend
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            funct3,
    input  logic [7:0]            lo,
    input  logic [7:0]            hi,
    input  logic [DATA_WIDTH-1:0] word,
    output logic [DATA_WIDTH-1:0] rdata
);

    always_comb begin
        rdata = '0;
        case (funct3)
            F3_B:    rdata = {{(DATA_WIDTH-8){lo[7]}}, lo};
            F3_BU:   rdata = {{(DATA_WIDTH-8){1'b0}}, lo};
            F3_H:    rdata = {{(DATA_WIDTH-16){hi[7]}}, hi, lo};
            F3_HU:   rdata = {{(DATA_WIDTH-16){1'b0}}, hi, lo};
            F3_W:    rdata = word;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, halfwords split into two
// byte accesses, single response pulse per request.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] MEM_TOP    = DATA_WIDTH'(MEM_TOP_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_WE,
    output logic [DATA_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic                  mem_ByteAddr,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    lsu_state_t            state, state_nxt;
    logic                  wr_q;
    logic [2:0]            f3_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [7:0]            wd_hi_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [7:0]            hi_q;
    logic [DATA_WIDTH-1:0] ext_rdata;

    // Halfword legality needs the second byte in range too; the wrapped
    // addr+1 of an all-ones address is already caught by the first term.
    logic [DATA_WIDTH-1:0] req_addr_p1;
    logic                  req_bad;
    assign req_addr_p1 = req_addr + DATA_WIDTH'(1);
    assign req_bad = !f3_legal(req_funct3) || (req_addr > MEM_TOP) ||
                     (f3_half(req_funct3) && (req_addr_p1 > MEM_TOP));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = req_bad ? RESP : ACC0;
            ACC0: state_nxt = f3_half(f3_q) ? ACC1 : RESP;
            ACC1: state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory port registers are loaded one edge ahead of the access cycle
    // so they are stable throughout ACC0/ACC1 and hold afterwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q         <= 1'b0;
            f3_q         <= F3_B;
            addr_q       <= '0;
            wd_hi_q      <= '0;
            err_q        <= 1'b0;
            word_q       <= '0;
            hi_q         <= '0;
            mem_A        <= '0;
            mem_WD       <= '0;
            mem_ByteAddr <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    wr_q    <= req_write;
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr;
                    wd_hi_q <= req_wdata[15:8];
                    err_q   <= req_bad;
                    if (!req_bad) begin
                        mem_A        <= req_addr;
                        mem_ByteAddr <= (req_funct3 != F3_W);
                        mem_WD       <= (req_funct3 == F3_W) ? req_wdata
                                                             : DATA_WIDTH'(req_wdata[7:0]);
                    end
                end
                ACC0: begin
                    if (!wr_q) word_q <= mem_RD;
                    if (f3_half(f3_q)) begin
                        mem_A  <= addr_q + DATA_WIDTH'(1);
                        mem_WD <= DATA_WIDTH'(wd_hi_q);
                    end
                end
                ACC1: if (!wr_q) hi_q <= mem_RD[7:0];
                default: ;
            endcase
        end
    end

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_ext (
        .funct3 (f3_q),
        .lo     (word_q[7:0]),
        .hi     (hi_q),
        .word   (word_q),
        .rdata  (ext_rdata)
    );

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = (resp_valid && !err_q && !wr_q) ? ext_rdata : '0;
    // Gated with reset so a reset edge mid-store never commits a write.
    assign mem_WE     = rst_n && wr_q && ((state == ACC0) || (state == ACC1));

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte-array memory model on the
// memory port, independent byte-array reference for expected results.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_WE, mem_ByteAddr;
    logic [31:0] mem_A, mem_WD, mem_RD;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD),
        .mem_ByteAddr(mem_ByteAddr), .mem_RD(mem_RD)
    );

    // Memory attached to the port
    bit [7:0] dmem [0:131071];

    always_comb begin
        logic [16:0] i;
        i = mem_A[16:0];
        if (mem_ByteAddr) mem_RD = {24'h0, dmem[i]};
        else mem_RD = {dmem[i + 17'd3], dmem[i + 17'd2], dmem[i + 17'd1], dmem[i]};
    end

    always @(posedge clk) begin
        if (mem_WE) begin
            if (mem_ByteAddr) dmem[mem_A[16:0]] <= mem_WD[7:0];
            else begin
                dmem[mem_A[16:0]]          <= mem_WD[7:0];
                dmem[mem_A[16:0] + 17'd1]  <= mem_WD[15:8];
                dmem[mem_A[16:0] + 17'd2]  <= mem_WD[23:16];
                dmem[mem_A[16:0] + 17'd3]  <= mem_WD[31:24];
            end
        end
    end

    // Reference model: architectural byte memory and RV32I rules
    bit [7:0] ref_mem [0:131071];
    int nchk = 0;
    int nfail = 0;

    function automatic bit model_err(input logic [2:0] f3, input logic [31:0] a);
        bit half;
        half = (f3 == 3'b001) || (f3 == 3'b101);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (a > 32'h1FFFF) return 1'b1;
        if (half && (a >= 32'h1FFFF)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        longint v;
        case (f3)
            3'b000: begin v = ref_mem[a[16:0]]; if (v >= 128) v -= 256; end
            3'b100: v = ref_mem[a[16:0]];
            3'b001: begin
                v = ref_mem[a[16:0]] + 256 * ref_mem[a[16:0] + 17'd1];
                if (v >= 32768) v -= 65536;
            end
            3'b101: v = ref_mem[a[16:0]] + 256 * ref_mem[a[16:0] + 17'd1];
            default: v = ref_mem[a[16:0]] + 256 * ref_mem[a[16:0] + 17'd1] +
                         65536 * ref_mem[a[16:0] + 17'd2] +
                         16777216 * longint'(ref_mem[a[16:0] + 17'd3]);
        endcase
        return v[31:0];
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = (f3 == 3'b010) ? 4 : ((f3 == 3'b001 || f3 == 3'b101) ? 2 : 1);
        for (int k = 0; k < n; k++) ref_mem[a[16:0] + 17'(k)] = wd[8*k +: 8];
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-cycle snapshot of the memory port between acceptance and response
    logic [31:0] cyc_a  [1:8];
    logic [31:0] cyc_wd [1:8];
    logic        cyc_ba [1:8];
    logic        cyc_we [1:8];
    int          last_lat;
    int          last_we;
    logic        last_err;
    logic [31:0] last_rdata;

    // Called right after the acceptance edge; samples on negedges.
    task automatic wait_resp(input string tag);
        bit got;
        got = 0; last_lat = 0; last_we = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                got = 1; last_lat = c;
                last_err = resp_err; last_rdata = resp_rdata;
            end else begin
                check({tag, " ready_busy"}, {31'b0, req_ready}, 32'd0);
                cyc_a[c] = mem_A; cyc_wd[c] = mem_WD;
                cyc_ba[c] = mem_ByteAddr; cyc_we[c] = mem_WE;
                if (mem_WE) last_we++;
            end
        end
        if (!got) begin
            nchk++; nfail++;
            $error("FAIL %s timeout: observed no resp_valid expected resp within 8 cycles", tag);
        end
    endtask

    task automatic do_req(input string tag, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        bit          e_err;
        int          e_lat, e_we;
        logic [31:0] e_rd;
        bit          half;
        half  = (f3 == 3'b001) || (f3 == 3'b101);
        e_err = model_err(f3, a);
        e_lat = e_err ? 1 : (half ? 3 : 2);
        e_we  = (e_err || !wr) ? 0 : (half ? 2 : 1);
        e_rd  = (e_err || wr) ? 32'h0 : model_load(f3, a);
        @(negedge clk);
        check({tag, " ready_idle"}, {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = $urandom_range(0, 1) == 1;
        req_addr = $urandom; req_wdata = $urandom;
        wait_resp(tag);
        check({tag, " latency"}, 32'(last_lat), 32'(e_lat));
        check({tag, " err"}, {31'b0, last_err}, {31'b0, e_err});
        check({tag, " rdata"}, last_rdata, e_rd);
        check({tag, " we_cycles"}, 32'(last_we), 32'(e_we));
        if (wr && !e_err) model_store(f3, a, wd);
    endtask

    initial begin
        logic [7:0] old_b;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b000; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst ready", {31'b0, req_ready}, 32'd1);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst resp_err", {31'b0, resp_err}, 32'd0);
        check("rst rdata", resp_rdata, 32'd0);
        check("rst mem_A", mem_A, 32'd0);
        check("rst mem_WD", mem_WD, 32'd0);
        check("rst ByteAddr", {31'b0, mem_ByteAddr}, 32'd0);
        check("rst WE", {31'b0, mem_WE}, 32'd0);
        rst_n = 1'b1;

        // Byte loads with sign and zero extension
        do_req("SB", 1, 3'b000, 32'h10000, 32'h12345680);
        do_req("LB", 0, 3'b000, 32'h10000, 32'h0);
        check("LB value", last_rdata, 32'hFFFFFF80);
        do_req("LBU", 0, 3'b100, 32'h10000, 32'h0);
        check("LBU value", last_rdata, 32'h00000080);

        // Halfword store split into two byte accesses
        do_req("SH", 1, 3'b001, 32'h10001, 32'h0000BEEF);
        check("SH acc0 WE", {31'b0, cyc_we[1]}, 32'd1);
        check("SH acc0 A", cyc_a[1], 32'h10001);
        check("SH acc0 BA", {31'b0, cyc_ba[1]}, 32'd1);
        check("SH acc0 WD", cyc_wd[1], 32'h000000EF);
        check("SH acc1 A", cyc_a[2], 32'h10002);
        check("SH acc1 WD", cyc_wd[2], 32'h000000BE);
        do_req("LH", 0, 3'b001, 32'h10001, 32'h0);
        check("LH value", last_rdata, 32'hFFFFBEEF);
        do_req("LHU", 0, 3'b101, 32'h10001, 32'h0);
        check("LHU value", last_rdata, 32'h0000BEEF);

        // Misaligned word
        do_req("SW", 1, 3'b010, 32'h10003, 32'hDEADBEEF);
        check("SW BA", {31'b0, cyc_ba[1]}, 32'd0);
        do_req("LW", 0, 3'b010, 32'h10003, 32'h0);
        check("LW BA", {31'b0, cyc_ba[1]}, 32'd0);
        check("LW value", last_rdata, 32'hDEADBEEF);

        // Errors: illegal funct3 and halfword crossing the top
        do_req("F3_011", 1, 3'b011, 32'h100, 32'hFFFFFFFF);
        check("F3_011 err", {31'b0, last_err}, 32'd1);
        do_req("LH_top", 0, 3'b001, 32'h1FFFF, 32'h0);
        check("LH_top err", {31'b0, last_err}, 32'd1);
        do_req("LB_top", 0, 3'b000, 32'h1FFFF, 32'h0);
        do_req("SW_over", 1, 3'b010, 32'h20000, 32'h11111111);

        // Held req_valid: second request waits for the return to IDLE
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b000; req_addr = 32'h10000;
        @(posedge clk); #1;
        wait_resp("HOLD1");
        check("HOLD1 latency", 32'(last_lat), 32'd2);
        check("HOLD1 rdata", last_rdata, 32'hFFFFFF80);
        check("HOLD resp ready", {31'b0, req_ready}, 32'd0);
        req_funct3 = 3'b100; req_addr = 32'h10004;
        @(negedge clk);
        check("HOLD idle ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        wait_resp("HOLD2");
        check("HOLD2 latency", 32'(last_lat), 32'd2);
        check("HOLD2 rdata", last_rdata, model_load(3'b100, 32'h10004));

        // Reset during ACC1 of a halfword store
        old_b = dmem[17'h10001];
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b001;
        req_addr = 32'h10000; req_wdata = 32'h0000AABB;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("RST acc0 WE", {31'b0, mem_WE}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0; #1;
        check("RST acc1 WE", {31'b0, mem_WE}, 32'd0);
        @(negedge clk);
        check("RST ready", {31'b0, req_ready}, 32'd1);
        check("RST resp_valid", {31'b0, resp_valid}, 32'd0);
        rst_n = 1'b1;
        check("RST low byte", {24'h0, dmem[17'h10000]}, 32'h000000BB);
        check("RST high byte", {24'h0, dmem[17'h10001]}, {24'h0, old_b});
        ref_mem[17'h10000] = 8'hBB;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("RST no resp", {31'b0, resp_valid}, 32'd0);
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            int   sel;
            bit   wr;
            logic [2:0]  f3;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            a   = 32'h10000 + $urandom_range(0, 47);
            wr  = $urandom_range(0, 1) == 1;
            case (sel)
                0, 1, 2: f3 = 3'b010;
                3, 4:    f3 = wr ? 3'b001 : 3'b101;
                5:       f3 = wr ? 3'b000 : 3'b100;
                6:       f3 = wr ? 3'b000 : 3'b001;
                7:       f3 = 3'b000;
                8: begin
                    int bad;
                    bad = $urandom_range(0, 2);
                    f3 = (bad == 0) ? 3'b011 : ((bad == 1) ? 3'b110 : 3'b111);
                end
                default: begin
                    f3 = 3'(($urandom_range(0, 1) == 1) ? 3'b001 : 3'b010);
                    a  = ($urandom_range(0, 1) == 1) ? 32'h1FFFF : 32'h20000 + $urandom_range(0, 255);
                end
            endcase
            do_req("RND", wr, f3, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
